seq_controller: RTL and testbench
=================================

Name: seq_controller

Overview:
Multi-cycle sequencer for the Y86-64 SEQ datapath. Owns the PC register, steps fetch/decode/execute/memory/writeback one stage per cycle, and handshakes with data memory. Also holds the processor status code and retires instructions. It drives PC into the fetch stage and uses fetch's icode, valC, valP, validity and memory-error outputs to decide the next state and next PC.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk_i  input  1  clock, rising edge.
rst_n_i  input  1  asynchronous active-low reset.
run_i  input  1  level; when high, execution proceeds; sampled only at instruction boundaries.
icode_i  input  4  icode from fetch.
instr_valid_i  input  1  fetch instruction-valid flag.
imem_error_i  input  1  fetch address-out-of-range flag.
valC_i  input  64  constant word from fetch.
valP_i  input  64  fall-through PC from fetch.
cnd_i  input  1  branch/cmov condition from execute.
valM_i  input  64  data read from memory.
dmem_ready_i  input  1  memory access complete.
dmem_error_i  input  1  memory address error; valid only with dmem_ready_i.
PC_o  output  64  current PC to fetch.
fetch_en_o, decode_en_o, execute_en_o, wb_en_o  output  1 each  stage strobes; one-hot by state.
dmem_req_o  output  1  memory request; held high throughout MEMORY.
stat_o  output  3  status: AOK=1, HLT=2, ADR=3, INS=4.
state_o  output  3  current state encoding, for debug.
retire_o  output  1  one-cycle pulse when an instruction commits its PC.
retire_cnt_o  output  CNT_W  count of retired instructions.

Behaviour:
- Reset values (asynchronous): PC_o=RESET_PC; state IDLE; stat_o=AOK; retire_cnt_o=0; every enable, dmem_req_o and retire_o at 0. Reset asserted in any state aborts the instruction immediately. No retire, no PC change.
- State encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, PCUPD=6, HALTED=7.
- IDLE: moves to FETCH when run_i=1.
- FETCH (fetch_en_o=1): checks are evaluated in this order.
  - imem_error_i: stat ADR, go to HALTED.
  - !instr_valid_i: stat INS, go to HALTED.
  - icode=0 (halt): stat HLT, go to HALTED.
  - Otherwise: latch icode, valC and valP, then go to DECODE.
- DECODE: always moves to EXECUTE.
- EXECUTE: latch cnd_i. Next state is MEMORY for icode 4, 5, 8, 9, A, B; WRITEBACK for all others.
- MEMORY: dmem_req_o=1 and stays in MEMORY until dmem_ready_i.
  - On ready with dmem_error_i: stat ADR, go to HALTED, no writeback.
  - On ready without error: latch valM_i, go to WRITEBACK.
- WRITEBACK: wb_en_o=1, then moves to PCUPD.
- PCUPD: PC_o is updated; retire_o=1; retire_cnt_o increments. Next state is FETCH if run_i, else IDLE.
- Next-PC selection:
  - CALL (8): valC.
  - JXX (7) with latched cnd=1: valC.
  - RET (9): latched valM.
  - Otherwise: valP.
- Latency: non-memory instruction takes 5 cycles (F,D,E,W,P). Memory instruction takes 6 cycles plus one cycle per cycle that dmem_ready_i is low.
- run_i falling mid-instruction has no effect until PCUPD; the instruction completes.
- HALTED is sticky until reset. PC_o holds the faulting/halt PC. No enables are driven. run_i is ignored.
- retire_cnt_o wraps from all-ones to 0.
- PC arithmetic is unsigned 64-bit, no overflow check. Address range checking belongs to fetch and memory.
- Halt and faulting instructions do not retire.

Decomposition:
- Icode constants (`IHALT ... `IPOPQ) already live in define.v. Add these there:
  - stat codes `SAOK/`SHLT/`SADR/`SINS;
  - state encodings;
  - the "needs memory" icode set.
- One combinational sub-module, pc_select: inputs icode, cnd, valC, valP, valM; output next PC. All sequencing stays in seq_controller.

Test Plan:
1. Reset, run_i=1, icode=3, valP=10 → PC 0→10 at the 5th edge after FETCH; retire_o pulses once; retire_cnt_o=1; no dmem_req_o.
2. icode=7, valC=0x50, valP=0x49, cnd=1 → PC=0x50. Repeat with cnd=0 → PC=0x49. 5 cycles each.
3. icode=9, dmem_ready_i low for 3 MEMORY cycles, valM=0x69 → dmem_req_o high 4 cycles; PC=0x69; total 9 cycles.
4. Fault checks:
   - icode=0 → stat_o=2, state_o=7, PC unchanged, retire_cnt unchanged; toggling run_i has no effect.
   - imem_error_i=1 → stat_o=3.
   - instr_valid_i=0 → stat_o=4.
5. icode=5 with dmem_ready_i=1 and dmem_error_i=1 → stat_o=3, wb_en_o never asserted, no retire.
6. run_i dropped during EXECUTE → instruction retires, then state IDLE. rst_n_i asserted in MEMORY → outputs at reset values before the next edge, retire_cnt_o=0.

Source files
------------

// File: rtl/seq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_controller_pkg
// Brief    : Y86-64 icodes, status codes, sequencer state encodings and the
//            memory-stage icode set shared by the SEQ controller.
// Revision : 1.0 - initial release
// ============================================================================
package seq_controller_pkg;

    typedef enum logic [3:0] {
        c_IHALT   = 4'h0,
        c_INOP    = 4'h1,
        c_IRRMOVQ = 4'h2,
        c_IIRMOVQ = 4'h3,
        c_IRMMOVQ = 4'h4,
        c_IMRMOVQ = 4'h5,
        c_IOPQ    = 4'h6,
        c_IJXX    = 4'h7,
        c_ICALL   = 4'h8,
        c_IRET    = 4'h9,
        c_IPUSHQ  = 4'hA,
        c_IPOPQ   = 4'hB
    } icode_e;

    localparam logic [2:0] c_SAOK = 3'd1;
    localparam logic [2:0] c_SHLT = 3'd2;
    localparam logic [2:0] c_SADR = 3'd3;
    localparam logic [2:0] c_SINS = 3'd4;

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FETCH     = 3'd1;
    localparam logic [2:0] c_S_DECODE    = 3'd2;
    localparam logic [2:0] c_S_EXECUTE   = 3'd3;
    localparam logic [2:0] c_S_MEMORY    = 3'd4;
    localparam logic [2:0] c_S_WRITEBACK = 3'd5;
    localparam logic [2:0] c_S_PCUPD     = 3'd6;
    localparam logic [2:0] c_S_HALTED    = 3'd7;

    // Instructions that touch data memory (loads, stores, stack ops).
    function automatic logic needs_mem(input logic [3:0] icode);
        return icode inside {c_IRMMOVQ, c_IMRMOVQ, c_ICALL, c_IRET, c_IPUSHQ, c_IPOPQ};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_controller_pc_select.sv
`default_nettype none
// ============================================================================
// Module   : pc_select
// Brief    : Combinational next-PC mux for the SEQ sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module pc_select
    import seq_controller_pkg::*;
(
    input  logic [3:0]  i_icode,
    input  logic        i_cnd,
    input  logic [63:0] i_valc,
    input  logic [63:0] i_valp,
    input  logic [63:0] i_valm,
    output logic [63:0] o_next_pc
);

    always_comb begin
        o_next_pc = i_valp;
        case (i_icode)
            c_ICALL: o_next_pc = i_valc;
            c_IJXX:  if (i_cnd) o_next_pc = i_valc;
            c_IRET:  o_next_pc = i_valm;
            default: o_next_pc = i_valp;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : seq_controller
// Brief    : Multi-cycle Y86-64 SEQ sequencer: PC, stage strobes, data-memory
//            handshake, status code and retired-instruction counter.
// Revision : 1.0 - initial release
// ============================================================================
module seq_controller
    import seq_controller_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic [3:0]       icode_i,
    input  logic             instr_valid_i,
    input  logic             imem_error_i,
    input  logic [63:0]      valC_i,
    input  logic [63:0]      valP_i,
    input  logic             cnd_i,
    input  logic [63:0]      valM_i,
    input  logic             dmem_ready_i,
    input  logic             dmem_error_i,
    output logic [63:0]      PC_o,
    output logic             fetch_en_o,
    output logic             decode_en_o,
    output logic             execute_en_o,
    output logic             wb_en_o,
    output logic             dmem_req_o,
    output logic [2:0]       stat_o,
    output logic [2:0]       state_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] retire_cnt_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [2:0]       r_stat;
    logic [2:0]       w_stat_nxt;
    logic [63:0]      r_pc;
    logic [63:0]      w_pc_nxt;
    logic [3:0]       r_icode;
    logic [63:0]      r_valc;
    logic [63:0]      r_valp;
    logic [63:0]      r_valm;
    logic             r_cnd;
    logic [CNT_W-1:0] r_retire_cnt;

    pc_select u_pc_select (
        .i_icode   (r_icode),
        .i_cnd     (r_cnd),
        .i_valc    (r_valc),
        .i_valp    (r_valp),
        .i_valm    (r_valm),
        .o_next_pc (w_pc_nxt)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_S_IDLE;
            r_stat  <= c_SAOK;
        end else begin
            r_state <= w_state_nxt;
            r_stat  <= w_stat_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_stat_nxt   = r_stat;
        fetch_en_o   = 1'b0;
        decode_en_o  = 1'b0;
        execute_en_o = 1'b0;
        wb_en_o      = 1'b0;
        dmem_req_o   = 1'b0;
        retire_o     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (run_i) w_state_nxt = c_S_FETCH;
            end
            c_S_FETCH: begin
                fetch_en_o = 1'b1;
                // Fault priority: address error, then bad encoding, then halt.
                if (imem_error_i) begin
                    w_stat_nxt  = c_SADR;
                    w_state_nxt = c_S_HALTED;
                end else if (!instr_valid_i) begin
                    w_stat_nxt  = c_SINS;
                    w_state_nxt = c_S_HALTED;
                end else if (icode_i == c_IHALT) begin
                    w_stat_nxt  = c_SHLT;
                    w_state_nxt = c_S_HALTED;
                end else begin
                    w_state_nxt = c_S_DECODE;
                end
            end
            c_S_DECODE: begin
                decode_en_o = 1'b1;
                w_state_nxt = c_S_EXECUTE;
            end
            c_S_EXECUTE: begin
                execute_en_o = 1'b1;
                w_state_nxt  = needs_mem(r_icode) ? c_S_MEMORY : c_S_WRITEBACK;
            end
            c_S_MEMORY: begin
                dmem_req_o = 1'b1;
                if (dmem_ready_i) begin
                    if (dmem_error_i) begin
                        w_stat_nxt  = c_SADR;
                        w_state_nxt = c_S_HALTED;
                    end else begin
                        w_state_nxt = c_S_WRITEBACK;
                    end
                end
            end
            c_S_WRITEBACK: begin
                wb_en_o     = 1'b1;
                w_state_nxt = c_S_PCUPD;
            end
            c_S_PCUPD: begin
                retire_o    = 1'b1;
                w_state_nxt = run_i ? c_S_FETCH : c_S_IDLE;
            end
            c_S_HALTED: begin
                w_state_nxt = c_S_HALTED;
            end
            default: begin
                w_state_nxt = c_S_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_pc         <= RESET_PC;
            r_retire_cnt <= '0;
            r_icode      <= '0;
            r_valc       <= '0;
            r_valp       <= '0;
            r_valm       <= '0;
            r_cnd        <= 1'b0;
        end else begin
            if (r_state == c_S_FETCH && w_state_nxt == c_S_DECODE) begin
                r_icode <= icode_i;
                r_valc  <= valC_i;
                r_valp  <= valP_i;
            end
            if (r_state == c_S_EXECUTE) begin
                r_cnd <= cnd_i;
            end
            if (r_state == c_S_MEMORY && dmem_ready_i && !dmem_error_i) begin
                r_valm <= valM_i;
            end
            // Commit point: the only place the PC and retire count move.
            if (r_state == c_S_PCUPD) begin
                r_pc         <= w_pc_nxt;
                r_retire_cnt <= r_retire_cnt + c_CNT_ONE;
            end
        end
    end

    assign PC_o         = r_pc;
    assign stat_o       = r_stat;
    assign state_o      = r_state;
    assign retire_cnt_o = r_retire_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_controller
// Brief    : Self-checking bench for seq_controller: vector table, corner
//            sequences and randomized instructions against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_controller;

    localparam int          TB_CNT_W    = 4;
    localparam logic [63:0] TB_RESET_PC = 64'h0;
    localparam logic [2:0]  ST_IDLE     = 3'd0;
    localparam logic [2:0]  ST_FETCH    = 3'd1;
    localparam logic [2:0]  ST_EXECUTE  = 3'd3;
    localparam logic [2:0]  ST_MEMORY   = 3'd4;
    localparam logic [2:0]  ST_HALTED   = 3'd7;

    logic                clk = 1'b0;
    logic                rst_n_i, run_i, instr_valid_i, imem_error_i, cnd_i;
    logic                dmem_ready_i, dmem_error_i;
    logic [3:0]          icode_i;
    logic [63:0]         valC_i, valP_i, valM_i, PC_o;
    logic                fetch_en_o, decode_en_o, execute_en_o, wb_en_o, dmem_req_o, retire_o;
    logic [2:0]          stat_o, state_o;
    logic [TB_CNT_W-1:0] retire_cnt_o;

    always #5 clk = ~clk;

    seq_controller #(.RESET_PC(TB_RESET_PC), .CNT_W(TB_CNT_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i), .run_i(run_i), .icode_i(icode_i),
        .instr_valid_i(instr_valid_i), .imem_error_i(imem_error_i),
        .valC_i(valC_i), .valP_i(valP_i), .cnd_i(cnd_i), .valM_i(valM_i),
        .dmem_ready_i(dmem_ready_i), .dmem_error_i(dmem_error_i), .PC_o(PC_o),
        .fetch_en_o(fetch_en_o), .decode_en_o(decode_en_o), .execute_en_o(execute_en_o),
        .wb_en_o(wb_en_o), .dmem_req_o(dmem_req_o), .stat_o(stat_o), .state_o(state_o),
        .retire_o(retire_o), .retire_cnt_o(retire_cnt_o)
    );

    typedef struct {
        logic [3:0]  icode;
        logic [63:0] valc, valp, valm;
        logic        cnd, derr, imem, valid;
        int          delay;
    } instr_t;

    typedef struct {
        logic [63:0] pc;
        logic [2:0]  stat;
        int          cyc, memc, wbc, ret;
    } exp_t;

    typedef struct {
        instr_t in;
        exp_t   ex;
    } vec_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    vec_t tbl[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] ic, input logic [63:0] vc, vp, vm,
                                input logic cn, de, im, va, input int dl,
                                input logic [63:0] epc, input logic [2:0] est,
                                input int ecyc, emem, ewb, eret);
        vec_t v;
        v.in.icode = ic;  v.in.valc = vc; v.in.valp = vp; v.in.valm = vm;
        v.in.cnd = cn;    v.in.derr = de; v.in.imem = im; v.in.valid = va; v.in.delay = dl;
        v.ex.pc = epc;    v.ex.stat = est; v.ex.cyc = ecyc; v.ex.memc = emem;
        v.ex.wbc = ewb;   v.ex.ret = eret;
        return v;
    endfunction

    // Outcome of one instruction, straight from the instruction-set rules.
    function automatic exp_t model(input instr_t t, input logic [63:0] pc);
        exp_t e;
        bit   mem;
        e.pc = pc; e.stat = 3'd1; e.cyc = 1; e.memc = 0; e.wbc = 0; e.ret = 0;
        if (t.imem)             e.stat = 3'd3;
        else if (!t.valid)      e.stat = 3'd4;
        else if (t.icode == 0)  e.stat = 3'd2;
        else begin
            mem = t.icode inside {4, 5, 8, 9, 10, 11};
            e.memc = mem ? t.delay + 1 : 0;
            if (mem && t.derr) begin
                e.stat = 3'd3;
                e.cyc  = 3 + e.memc;
            end else begin
                e.cyc = 5 + e.memc;
                e.wbc = 1;
                e.ret = 1;
                if (t.icode == 8 || (t.icode == 7 && t.cnd)) e.pc = t.valc;
                else if (t.icode == 9)                       e.pc = t.valm;
                else                                         e.pc = t.valp;
            end
        end
        return e;
    endfunction

    task automatic wait_state(input logic [2:0] s, input string name);
        int n = 0;
        while (state_o !== s && n < 32) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (state_o !== s) begin
            n_fail++;
            $display("FAIL %s: state %0d, expected %0d", name, state_o, s);
        end
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0; run_i = 1'b0; icode_i = 4'h1; instr_valid_i = 1'b1;
        imem_error_i = 1'b0; valC_i = '0; valP_i = '0; valM_i = '0; cnd_i = 1'b0;
        dmem_ready_i = 1'b0; dmem_error_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    task automatic start_run();
        do_reset();
        run_i = 1'b1;
        wait_state(ST_FETCH, "start_fetch");
    endtask

    // Runs one instruction from FETCH to the next boundary state.
    task automatic exec(input instr_t t, input bit drop, output int cyc, output int memc,
                        output int wbc, output int ret);
        bit done = 1'b0;
        cyc = 0; memc = 0; wbc = 0; ret = 0;
        icode_i = t.icode; valC_i = t.valc; valP_i = t.valp; valM_i = t.valm;
        cnd_i = t.cnd; dmem_error_i = t.derr; imem_error_i = t.imem; instr_valid_i = t.valid;
        while (!done && cyc < 64) begin
            if (dmem_req_o) begin
                memc++;
                dmem_ready_i = (memc > t.delay);
            end else begin
                dmem_ready_i = 1'b0;
            end
            if (wb_en_o)  wbc++;
            if (retire_o) ret++;
            if (drop && state_o == ST_EXECUTE) run_i = 1'b0;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = (state_o == ST_FETCH || state_o == ST_IDLE || state_o == ST_HALTED);
        end
        dmem_ready_i = 1'b0;
        imem_error_i = 1'b0;
        instr_valid_i = 1'b1;
    endtask

    task automatic check_instr(input string tag, input exp_t e, input int cyc, memc, wbc, ret,
                               input logic [TB_CNT_W-1:0] cnt, input logic [2:0] st);
        check({tag, "_pc"},   PC_o, e.pc);
        check({tag, "_stat"}, stat_o, e.stat);
        check({tag, "_cyc"},  cyc, e.cyc);
        check({tag, "_mem"},  memc, e.memc);
        check({tag, "_wb"},   wbc, e.wbc);
        check({tag, "_ret"},  ret, e.ret);
        check({tag, "_cnt"},  retire_cnt_o, cnt);
        check({tag, "_st"},   state_o, st);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int                  cyc, memc, wbc, ret;
        instr_t              t;
        exp_t                e;
        logic [63:0]         pc_m;
        logic [TB_CNT_W-1:0] cnt_m;
        bit                  drop;

        //           ic    valC    valP    valM  cnd de im va dl |  PC   stat cyc mem wb ret
        tbl[0]  = mk(4'h3, 64'h0,   64'd10, 64'h0,  0, 0, 0, 1, 0, 64'd10,  3'd1, 5, 0, 1, 1);
        tbl[1]  = mk(4'h7, 64'h50,  64'h49, 64'h0,  1, 0, 0, 1, 0, 64'h50,  3'd1, 5, 0, 1, 1);
        tbl[2]  = mk(4'h7, 64'h50,  64'h49, 64'h0,  0, 0, 0, 1, 0, 64'h49,  3'd1, 5, 0, 1, 1);
        tbl[3]  = mk(4'h9, 64'h0,   64'h20, 64'h69, 0, 0, 0, 1, 3, 64'h69,  3'd1, 9, 4, 1, 1);
        tbl[4]  = mk(4'h0, 64'h0,   64'h1,  64'h0,  0, 0, 0, 1, 0, 64'h0,   3'd2, 1, 0, 0, 0);
        tbl[5]  = mk(4'h3, 64'h0,   64'd10, 64'h0,  0, 0, 1, 1, 0, 64'h0,   3'd3, 1, 0, 0, 0);
        tbl[6]  = mk(4'h3, 64'h0,   64'd10, 64'h0,  0, 0, 0, 0, 0, 64'h0,   3'd4, 1, 0, 0, 0);
        tbl[7]  = mk(4'h5, 64'h0,   64'd10, 64'h0,  0, 1, 0, 1, 0, 64'h0,   3'd3, 4, 1, 0, 0);
        tbl[8]  = mk(4'h8, 64'h100, 64'h9,  64'h77, 0, 0, 0, 1, 0, 64'h100, 3'd1, 6, 1, 1, 1);
        tbl[9]  = mk(4'h6, 64'h33,  64'h2,  64'h0,  1, 0, 0, 1, 0, 64'h2,   3'd1, 5, 0, 1, 1);
        tbl[10] = mk(4'hB, 64'h0,   64'h7,  64'h55, 0, 0, 0, 1, 1, 64'h7,   3'd1, 7, 2, 1, 1);
        tbl[11] = mk(4'h3, 64'h0,   64'd10, 64'h0,  0, 0, 1, 0, 0, 64'h0,   3'd3, 1, 0, 0, 0);
        tbl[12] = mk(4'h0, 64'h0,   64'd10, 64'h0,  0, 0, 0, 0, 0, 64'h0,   3'd4, 1, 0, 0, 0);
        tbl[13] = mk(4'hA, 64'h0,   64'd10, 64'h0,  0, 1, 0, 1, 2, 64'h0,   3'd3, 6, 3, 0, 0);

        rst_n_i = 1'b1;
        @(negedge clk);
        do_reset();
        check("rst_pc", PC_o, TB_RESET_PC);
        check("rst_state", state_o, ST_IDLE);
        check("rst_stat", stat_o, 3'd1);
        check("rst_cnt", retire_cnt_o, 0);
        check("rst_strobes", {fetch_en_o, decode_en_o, execute_en_o, wb_en_o, dmem_req_o, retire_o}, 6'b0);
        repeat (3) @(negedge clk);
        check("idle_hold", state_o, ST_IDLE);

        for (int i = 0; i < 14; i++) begin
            start_run();
            exec(tbl[i].in, 1'b0, cyc, memc, wbc, ret);
            check_instr($sformatf("tbl%0d", i), tbl[i].ex, cyc, memc, wbc, ret,
                        TB_CNT_W'(tbl[i].ex.ret), (tbl[i].ex.stat == 3'd1) ? ST_FETCH : ST_HALTED);
        end

        // Halt is sticky: PC and count frozen, run_i ignored.
        start_run();
        t = tbl[0].in; t.valp = 64'h40;
        exec(t, 1'b0, cyc, memc, wbc, ret);
        t.icode = 4'h0;
        exec(t, 1'b0, cyc, memc, wbc, ret);
        for (int k = 0; k < 6; k++) begin
            run_i = ~run_i;
            @(negedge clk);
            check("halt_state", state_o, ST_HALTED);
            check("halt_strobes", {fetch_en_o, decode_en_o, execute_en_o, wb_en_o, dmem_req_o, retire_o}, 6'b0);
        end
        check("halt_pc", PC_o, 64'h40);
        check("halt_stat", stat_o, 3'd2);
        check("halt_cnt", retire_cnt_o, 1);

        // run_i dropped in EXECUTE: instruction still completes, then IDLE.
        start_run();
        t = tbl[0].in; t.icode = 4'h2; t.valp = 64'h18;
        exec(t, 1'b1, cyc, memc, wbc, ret);
        check("drop_ret", ret, 1);
        check("drop_state", state_o, ST_IDLE);
        check("drop_pc", PC_o, 64'h18);
        repeat (3) @(negedge clk);
        check("drop_idle_hold", state_o, ST_IDLE);
        run_i = 1'b1;
        wait_state(ST_FETCH, "drop_resume");

        // Asynchronous reset while stalled in MEMORY.
        icode_i = 4'h4; valP_i = 64'h99; dmem_ready_i = 1'b0;
        wait_state(ST_MEMORY, "mid_mem");
        check("mid_req", dmem_req_o, 1'b1);
        check("mid_cnt_before", retire_cnt_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        check("arst_state", state_o, ST_IDLE);
        check("arst_pc", PC_o, TB_RESET_PC);
        check("arst_cnt", retire_cnt_o, 0);
        check("arst_stat", stat_o, 3'd1);
        check("arst_strobes", {fetch_en_o, decode_en_o, execute_en_o, wb_en_o, dmem_req_o, retire_o}, 6'b0);
        @(negedge clk);
        rst_n_i = 1'b1;

        // Counter wrap: 16 retires on a 4-bit counter return it to zero.
        start_run();
        t = tbl[0].in; t.icode = 4'h1;
        for (int k = 1; k <= 17; k++) begin
            t.valp = 64'(k * 2);
            exec(t, 1'b0, cyc, memc, wbc, ret);
        end
        check("wrap_cnt", retire_cnt_o, 1);
        check("wrap_pc", PC_o, 64'd34);

        // Randomized instruction stream against the reference model.
        start_run();
        pc_m = TB_RESET_PC;
        cnt_m = '0;
        for (int k = 0; k < 80; k++) begin
            t.icode = 4'($urandom_range(1, 11));
            t.valc  = {$urandom, $urandom};
            t.valp  = {$urandom, $urandom};
            t.valm  = {$urandom, $urandom};
            t.cnd   = 1'($urandom_range(0, 1));
            t.delay = $urandom_range(0, 3);
            t.derr = 1'b0; t.imem = 1'b0; t.valid = 1'b1;
            case ($urandom_range(0, 19))
                0:       t.imem  = 1'b1;
                1:       t.valid = 1'b0;
                2:       t.icode = 4'h0;
                3:       t.derr  = 1'b1;
                default: ;
            endcase
            drop = ($urandom_range(0, 7) == 0);
            e = model(t, pc_m);
            cnt_m = cnt_m + TB_CNT_W'(e.ret);
            exec(t, drop, cyc, memc, wbc, ret);
            check_instr($sformatf("rnd%0d", k), e, cyc, memc, wbc, ret, cnt_m,
                        (e.stat != 3'd1) ? ST_HALTED : (drop ? ST_IDLE : ST_FETCH));
            pc_m = e.pc;
            if (e.stat != 3'd1) begin
                start_run();
                pc_m = TB_RESET_PC;
                cnt_m = '0;
            end else if (drop) begin
                run_i = 1'b1;
                wait_state(ST_FETCH, "rnd_resume");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
